pid_param: RTL and testbench
============================

PID_PARAM -- requirements
Module: pid_param

Interface
REQ-001 SHALL provide parameter IN_W, default 16: width of signed pitch and pitch-rate inputs.
REQ-002 SHALL provide parameter ERR_W, default 10: width of saturated signed error.
REQ-003 SHALL provide parameter INT_W, default 18: width of signed integrator.
REQ-004 SHALL provide parameter OUT_W, default 12: width of signed control output.
REQ-005 SHALL provide parameter SS_W, default 8: width of soft-start timer output.
REQ-006 SHALL provide parameter FAST_SIM, default 0: 1 selects accelerated soft-start timer.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, with ports as follows (clock and reset first):
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new ptch/ptch_rt sample valid, single-cycle
pwr_up  in  1  power enable; low clears timer
rider_off  in  1  rider absent; clears integrator and output path
ptch  in  IN_W  signed pitch error
ptch_rt  in  IN_W  signed pitch rate
kp  in  5  unsigned proportional gain
ki_shft  in  3  integrator arithmetic right-shift amount
kd_shft  in  3  pitch-rate arithmetic right-shift amount
PID_cntrl  out  OUT_W  signed saturated, slew-limited control
cntrl_vld  out  1  one-cycle pulse, PID_cntrl updated
sat_flag  out  1  last output was clamped
ss_tmr  out  SS_W  soft-start timer, top SS_W bits of counter

Function
REQ-008 SHALL saturate ptch to ERR_W signed: max 2^(ERR_W-1)-1, min -2^(ERR_W-1).
REQ-009 SHALL form P = err_sat * kp (kp zero-extended, signed product, ERR_W+6 bits).
REQ-010 SHALL form I = integrator >>> ki_shft (arithmetic), using integrator value before the same-cycle accumulation.
REQ-011 SHALL form D = -(ptch_rt >>> kd_shft) (arithmetic, sign-correct, no wrap at most-negative input).
REQ-012 SHALL, on vld, register P, I, D into stage 1 and set a stage-1 valid bit; stage-1 registers hold otherwise.
REQ-013 SHALL, one cycle after stage-1 valid, sum P+I+D at full width, saturate to OUT_W, apply soft-start clamp, register into PID_cntrl and pulse cntrl_vld; latency vld -> cntrl_vld = 2 cycles.
REQ-014 SHALL hold PID_cntrl between updates; back-to-back vld yields back-to-back cntrl_vld.
REQ-015 SHALL soft-start clamp output to [-L, +L], L = ss_tmr << (OUT_W-1-SS_W); clamp disabled when ss_tmr all ones.
REQ-016 SHALL register sat_flag with each PID_cntrl update: 1 if OUT_W saturation or soft-start clamp changed the value.
REQ-017 SHALL accumulate err_sat (sign-extended) into integrator on vld only if the signed add does not overflow INT_W (sign-check) and not (sat_flag=1 and err_sat sign equals PID_cntrl sign) (anti-windup).
REQ-018 SHALL keep an (SS_W+19)-bit counter: +1 per cycle (+256 if FAST_SIM) while pwr_up, stop when top SS_W bits all ones, clear synchronously when pwr_up=0; ss_tmr = top SS_W bits.
REQ-019 SHALL, while rider_off=1 (priority over vld): clear integrator, stage-1 valid, PID_cntrl, sat_flag; suppress cntrl_vld.
REQ-020 SHALL not affect the timer with rider_off.

Reset
REQ-021 SHALL asynchronously on rst_n=0 clear integrator, counter, stage-1 registers and valid, PID_cntrl=0, cntrl_vld=0, sat_flag=0, ss_tmr=0.
REQ-022 SHALL honour reset mid-pipeline: an in-flight sample produces no cntrl_vld after release.

Verification
REQ-023 Reset asserted mid-run -> all outputs 0 immediately, no cntrl_vld after release without new vld.
REQ-024 FAST_SIM=1, timer saturated, kp=9, ki_shft=6, kd_shft=6, integrator 0, ptch=0x0040, ptch_rt=0, one vld -> cntrl_vld 2 cycles later, PID_cntrl=576 (0x240), sat_flag=0.
REQ-025 Timer saturated, ptch=0x0000, ptch_rt=0x0400, vld -> PID_cntrl=-16 (0xFF0).
REQ-026 Timer saturated, ptch=0x7000 (err_sat=511, P=4599), vld -> PID_cntrl=0x7FF, sat_flag=1; next vld with same ptch -> integrator unchanged.
REQ-027 ss_tmr=16 (L=128), ptch=0x0040, vld -> PID_cntrl=128, sat_flag=1; pwr_up=0 -> ss_tmr=0 next cycle, next output 0.
REQ-028 Integrator at 2^17-100, ptch=0x01FF, vld -> integrator unchanged (overflow blocked); rider_off=1 -> integrator 0, PID_cntrl 0 next cycle.

Source files
------------

// File: rtl/pid_param.sv
// pid_param: two-stage PID controller for a self-balancing platform.
//
// Stage 1 (on vld): saturate pitch error, form P = err*kp, I = integrator>>>ki_shft,
//   D = -(ptch_rt>>>kd_shft), and update the integrator with overflow and
//   anti-windup protection.
// Stage 2 (one cycle later): sum P+I+D at full width, saturate to OUT_W,
//   apply the soft-start clamp, register into PID_cntrl and pulse cntrl_vld.
// A soft-start counter ramps while pwr_up is high; its top SS_W bits are ss_tmr.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vld               new ptch/ptch_rt sample (single-cycle strobe)
//   pwr_up            power enable; low clears the soft-start counter
//   rider_off         rider absent; clears integrator and output path
//   ptch, ptch_rt     signed pitch error / pitch rate (IN_W)
//   kp, ki_shft, kd_shft  gains
//   PID_cntrl         signed, saturated, soft-start-limited control (OUT_W)
//   cntrl_vld         one-cycle pulse when PID_cntrl is updated
//   sat_flag          last update was clamped
//   ss_tmr            soft-start timer (SS_W)
//
// Handshake: there is no back-pressure. Every cycle with vld=1 (and rider_off=0)
// is accepted; exactly two cycles later cntrl_vld pulses for one cycle with the
// result. Back-to-back vld gives back-to-back cntrl_vld.
module pid_param #(
  parameter int IN_W     = 16,
  parameter int ERR_W    = 10,
  parameter int INT_W    = 18,
  parameter int OUT_W    = 12,
  parameter int SS_W     = 8,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic signed [IN_W-1:0]  ptch,
  input  logic signed [IN_W-1:0]  ptch_rt,
  input  logic [4:0]              kp,
  input  logic [2:0]              ki_shft,
  input  logic [2:0]              kd_shft,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    cntrl_vld,
  output logic                    sat_flag,
  output logic [SS_W-1:0]         ss_tmr
);

  localparam int P_W    = ERR_W + 6;
  localparam int D_W    = IN_W + 1;  // one extra bit so negating the most-negative rate cannot wrap
  localparam int MAX_W  = (P_W > INT_W) ? ((P_W > D_W) ? P_W : D_W)
                                        : ((INT_W > D_W) ? INT_W : D_W);
  localparam int SUM_W  = MAX_W + 2;  // headroom for a three-term sum
  localparam int CNT_W  = SS_W + 19;
  localparam int LIM_SH = OUT_W - 1 - SS_W;

  localparam logic [CNT_W-1:0] CNT_INC = (FAST_SIM != 0) ? CNT_W'(256) : CNT_W'(1);
  localparam logic signed [IN_W-1:0]  ERR_HI = IN_W'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [IN_W-1:0]  ERR_LO = IN_W'(-(2 ** (ERR_W - 1)));
  localparam logic signed [SUM_W-1:0] OUT_HI = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_LO = SUM_W'(-(2 ** (OUT_W - 1)));

  // ---------------- soft-start timer ----------------
  logic [CNT_W-1:0] cnt;
  logic             ss_full;

  assign ss_tmr  = cnt[CNT_W-1 -: SS_W];
  assign ss_full = &ss_tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (!pwr_up)  cnt <= '0;
    else if (!ss_full) cnt <= cnt + CNT_INC;
  end

  // ---------------- stage 1 terms ----------------
  logic signed [ERR_W-1:0] err_sat;
  logic signed [P_W-1:0]   p_term;
  logic signed [INT_W-1:0] i_term;
  logic signed [D_W-1:0]   d_term;
  logic signed [INT_W-1:0] integ, err_ext, integ_sum;
  logic                    integ_ovf, windup;

  always_comb begin
    if (ptch > ERR_HI)      err_sat = ERR_HI[ERR_W-1:0];
    else if (ptch < ERR_LO) err_sat = ERR_LO[ERR_W-1:0];
    else                    err_sat = ptch[ERR_W-1:0];
  end

  // kp is zero-extended so the product stays a signed multiply.
  assign p_term = P_W'(err_sat) * P_W'($signed({1'b0, kp}));
  assign i_term = integ >>> ki_shft;
  assign d_term = -(D_W'(ptch_rt) >>> kd_shft);

  assign err_ext   = INT_W'(err_sat);
  assign integ_sum = integ + err_ext;
  // Overflow: operands share a sign but the sum's sign differs.
  assign integ_ovf = (integ[INT_W-1] == err_ext[INT_W-1]) &&
                     (integ_sum[INT_W-1] != integ[INT_W-1]);
  // Anti-windup: do not push further in the direction the output is already clamped.
  assign windup    = sat_flag && (err_sat[ERR_W-1] == PID_cntrl[OUT_W-1]);

  logic signed [P_W-1:0]   p_s1;
  logic signed [INT_W-1:0] i_s1;
  logic signed [D_W-1:0]   d_s1;
  logic                    s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ  <= '0;
      p_s1   <= '0;
      i_s1   <= '0;
      d_s1   <= '0;
      s1_vld <= 1'b0;
    end else if (rider_off) begin
      integ  <= '0;
      s1_vld <= 1'b0;
    end else if (vld) begin
      p_s1   <= p_term;
      i_s1   <= i_term;  // integrator value before this sample's accumulation
      d_s1   <= d_term;
      s1_vld <= 1'b1;
      if (!integ_ovf && !windup) integ <= integ_sum;
    end else begin
      s1_vld <= 1'b0;
    end
  end

  // ---------------- stage 2: sum, saturate, soft-start clamp ----------------
  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] sat_val, lim, clamped;
  logic                    clip;

  assign sum = SUM_W'(p_s1) + SUM_W'(i_s1) + SUM_W'(d_s1);
  assign lim = OUT_W'(ss_tmr) << LIM_SH;

  always_comb begin
    if (sum > OUT_HI)      sat_val = OUT_HI[OUT_W-1:0];
    else if (sum < OUT_LO) sat_val = OUT_LO[OUT_W-1:0];
    else                   sat_val = sum[OUT_W-1:0];
    clamped = sat_val;
    if (!ss_full) begin
      if (sat_val > lim)       clamped = lim;
      else if (sat_val < -lim) clamped = -lim;
    end
  end

  assign clip = (SUM_W'(clamped) != sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl <= '0;
      cntrl_vld <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (rider_off) begin
      PID_cntrl <= '0;
      cntrl_vld <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (s1_vld) begin
      PID_cntrl <= clamped;
      cntrl_vld <= 1'b1;
      sat_flag  <= clip;
    end else begin
      cntrl_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pid_param.sv
// Testbench for pid_param: random stimulus checked every cycle against an
// integer-arithmetic model, plus hand-computed directed cases.
// The DUT runs with SS_W=4 and FAST_SIM=1 so the soft-start timer saturates
// in about 30k cycles; with OUT_W=12 the clamp is L = ss_tmr << 7.
module tb_pid_param;
  localparam int IN_W   = 16;
  localparam int ERR_W  = 10;
  localparam int INT_W  = 18;
  localparam int OUT_W  = 12;
  localparam int SS_W   = 4;
  localparam int SS_MAX = (1 << SS_W) - 1;
  localparam int LIM_SH = OUT_W - 1 - SS_W;
  localparam int IMAX   = (1 << (INT_W - 1)) - 1;
  localparam int IMIN   = -(1 << (INT_W - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0, pwr_up = 1'b0, rider_off = 1'b0;
  logic signed [IN_W-1:0] ptch = '0, ptch_rt = '0;
  logic [4:0] kp = '0;
  logic [2:0] ki_shft = '0, kd_shft = '0;
  logic signed [OUT_W-1:0] PID_cntrl;
  logic cntrl_vld, sat_flag;
  logic [SS_W-1:0] ss_tmr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pid_param #(.IN_W(IN_W), .ERR_W(ERR_W), .INT_W(INT_W), .OUT_W(OUT_W),
              .SS_W(SS_W), .FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .pwr_up(pwr_up), .rider_off(rider_off),
    .ptch(ptch), .ptch_rt(ptch_rt), .kp(kp), .ki_shft(ki_shft), .kd_shft(kd_shft),
    .PID_cntrl(PID_cntrl), .cntrl_vld(cntrl_vld), .sat_flag(sat_flag), .ss_tmr(ss_tmr)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_integ, m_p, m_i, m_d, m_out, m_cnt;
  bit m_pend, m_sat, m_cv;
  logic [OUT_W:0] exp_q[$];  // {sat_flag, PID_cntrl} per expected update

  function automatic int clip_to(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_integ = 0; m_p = 0; m_i = 0; m_d = 0; m_out = 0; m_cnt = 0;
    m_pend = 0; m_sat = 0; m_cv = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int ss, s, o, lim, err, n_out;
    bit n_sat, n_cv;
    ss = m_cnt >> 19;
    n_out = m_out; n_sat = m_sat; n_cv = 0;
    // output of the sample accepted last cycle
    if (rider_off) begin
      n_out = 0; n_sat = 0;
    end else if (m_pend) begin
      s = m_p + m_i + m_d;
      o = clip_to(s, OUT_W);
      if (ss != SS_MAX) begin
        lim = ss << LIM_SH;
        if (o > lim) o = lim;
        if (o < -lim) o = -lim;
      end
      n_out = o; n_sat = (o != s); n_cv = 1;
      exp_q.push_back({n_sat, OUT_W'(o)});
    end
    // new sample acceptance, using the outputs as they stood before this edge
    if (rider_off) begin
      m_integ = 0; m_pend = 0;
    end else if (vld) begin
      err = clip_to(int'(ptch), ERR_W);
      m_p = err * int'(kp);
      m_i = m_integ >>> ki_shft;
      m_d = -(int'(ptch_rt) >>> kd_shft);
      if ((m_integ + err <= IMAX) && (m_integ + err >= IMIN) &&
          !(m_sat && ((err < 0) == (m_out < 0))))
        m_integ = m_integ + err;
      m_pend = 1;
    end else begin
      m_pend = 0;
    end
    m_out = n_out; m_sat = n_sat; m_cv = n_cv;
    if (!pwr_up) m_cnt = 0;
    else if (ss != SS_MAX) m_cnt = m_cnt + 256;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    logic [OUT_W:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cntrl_vld", int'(cntrl_vld), int'(m_cv));
        check("PID_cntrl", int'(PID_cntrl), m_out);
        check("sat_flag", int'(sat_flag), int'(m_sat));
        check("ss_tmr", int'(ss_tmr), m_cnt >> 19);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("update", int'({sat_flag, PID_cntrl}), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int p, input int r, input int g, input int ki, input int kd);
    @(negedge clk);
    ptch = IN_W'(p); ptch_rt = IN_W'(r);
    kp = 5'(g); ki_shft = 3'(ki); kd_shft = 3'(kd);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);  // result visible here, two edges after acceptance
  endtask

  task automatic clear_rider(input string name);
    @(negedge clk);
    rider_off = 1'b1;
    @(negedge clk);
    check({name, "_PID"}, int'(PID_cntrl), 0);
    check({name, "_vld"}, int'(cntrl_vld), 0);
    check({name, "_sat"}, int'(sat_flag), 0);
    rider_off = 1'b0;
  endtask

  task automatic wait_ss(input int target, input int budget, input string name);
    int n = 0;
    while (int'(ss_tmr) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(ss_tmr), target);
  endtask

  task automatic rand_cycles(input int n, input bit until_full);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (until_full && int'(ss_tmr) == SS_MAX) break;
      vld = 1'($urandom_range(0, 1));
      rider_off = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1) ptch = IN_W'($urandom);
      else ptch = IN_W'(int'($urandom_range(0, 1200)) - 600);
      if ($urandom_range(0, 15) == 0) ptch_rt = IN_W'(-32768);
      else ptch_rt = IN_W'($urandom);
      kp = 5'($urandom);
      ki_shft = 3'($urandom);
      kd_shft = 3'($urandom);
    end
    vld = 1'b0;
    rider_off = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_PID", int'(PID_cntrl), 0);
    check("reset_vld", int'(cntrl_vld), 0);
    check("reset_sat", int'(sat_flag), 0);
    check("reset_ss", int'(ss_tmr), 0);
    rst_n = 1'b1;
    pwr_up = 1'b1;

    // Soft-start clamp at ss_tmr=1 (L=128), then power-down.
    wait_ss(1, 2200, "ss_reach_1");
    clear_rider("clr0");
    send(64, 0, 9, 6, 6);
    check("clamp_PID", int'(PID_cntrl), 128);
    check("clamp_sat", int'(sat_flag), 1);
    @(negedge clk);
    pwr_up = 1'b0;
    @(negedge clk);
    check("pwr_off_ss", int'(ss_tmr), 0);
    send(64, 0, 9, 6, 6);
    check("pwr_off_PID", int'(PID_cntrl), 0);
    check("pwr_off_sat", int'(sat_flag), 1);
    pwr_up = 1'b1;

    // Random traffic while the timer ramps to saturation.
    rand_cycles(40000, 1'b1);
    check("ss_full", int'(ss_tmr), SS_MAX);

    // Timer saturated: directed cases.
    clear_rider("clr1");
    send(64, 0, 9, 6, 6);
    check("p_only_PID", int'(PID_cntrl), 576);
    check("p_only_sat", int'(sat_flag), 0);
    check("p_only_vld", int'(cntrl_vld), 1);

    clear_rider("clr2");
    send(0, 1024, 9, 6, 6);
    check("d_only_PID", int'(PID_cntrl), -16);
    check("d_only_sat", int'(sat_flag), 0);

    clear_rider("clr3");
    send(28672, 0, 9, 6, 6);
    check("sat_hi_PID", int'(PID_cntrl), 2047);
    check("sat_hi_sat", int'(sat_flag), 1);
    send(28672, 0, 9, 6, 6);
    check("sat_hi2_PID", int'(PID_cntrl), 2047);
    send(0, 0, 0, 0, 0);
    check("windup_integ", int'(PID_cntrl), 511);
    check("windup_sat", int'(sat_flag), 0);

    // Drive the integrator to 2^17-100, then try to overflow it.
    clear_rider("clr4");
    for (int k = 0; k < 256; k++) send(511, 0, 0, 7, 0);
    send(156, 0, 0, 7, 0);
    send(511, 0, 0, 7, 0);
    check("ovf_pre_PID", int'(PID_cntrl), 1023);
    send(0, 0, 0, 7, 0);
    check("ovf_block_PID", int'(PID_cntrl), 1023);
    clear_rider("clr5");
    send(0, 0, 0, 7, 0);
    check("rider_integ", int'(PID_cntrl), 0);

    // More random traffic with the timer saturated.
    rand_cycles(3000, 1'b0);

    // Reset with a sample in flight.
    @(negedge clk);
    ptch = IN_W'(64); ptch_rt = '0; kp = 5'd9; ki_shft = 3'd6; kd_shft = 3'd6;
    vld = 1'b1;
    @(posedge clk);
    #2;
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_PID", int'(PID_cntrl), 0);
    check("midrst_vld", int'(cntrl_vld), 0);
    check("midrst_sat", int'(sat_flag), 0);
    check("midrst_ss", int'(ss_tmr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_vld", int'(cntrl_vld), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares",
             vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
